// File: rtl/march_bist_ctrl.sv
// March C- memory BIST controller: sequences the RAM through six march elements and
// records the first mismatch. Optional macro BIST_CONT_ON_FAIL_EN: run to completion and count errors.
module march_bist_ctrl #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int ADDR_LAST = 255,
  parameter int RD_LAT    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_wr,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_elem,
  output logic [DW-1:0] fail_exp,
  output logic [DW-1:0] fail_act
`ifdef BIST_CONT_ON_FAIL_EN
  ,
  output logic [15:0]   err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, OP, RDWAIT, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(ADDR_LAST);

  state_t        state_q, state_d;
  logic [2:0]    elem_q, elem_d;
  logic          op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [AW-1:0] faddr_q, faddr_d;
  logic [2:0]    felem_q, felem_d;
  logic [DW-1:0] fexp_q, fexp_d;
  logic [DW-1:0] fact_q, fact_d;
`ifdef BIST_CONT_ON_FAIL_EN
  logic [15:0]   err_q, err_d;
`endif

  logic          is_rd, cmp_en, advance, mism, first, at_end, fin, stop;
  logic [2:0]    nxt_elem;
  logic          nxt_op;
  logic [AW-1:0] nxt_addr;

  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic [DW-1:0] rd_exp(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? {DW{1'b1}} : {DW{1'b0}};
  endfunction

  function automatic logic [DW-1:0] wr_val(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? {DW{1'b1}} : {DW{1'b0}};
  endfunction

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    faddr_d = faddr_q;
    felem_d = felem_q;
    fexp_d  = fexp_q;
    fact_d  = fact_q;
`ifdef BIST_CONT_ON_FAIL_EN
    err_d   = err_q;
`endif
    // op_q marks the write half of an r/w pair; E0 is write-only, E5 read-only
    is_rd   = (elem_q != 3'd0) && !op_q;
    cmp_en  = 1'b0;
    advance = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = OP;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          faddr_d = '0;
          felem_d = '0;
          fexp_d  = '0;
          fact_d  = '0;
`ifdef BIST_CONT_ON_FAIL_EN
          err_d   = '0;
`endif
          elem_d  = 3'd0;
          op_d    = 1'b0;
          addr_d  = '0;
          wr_d    = 1'b1;
          din_d   = '0;
        end
      end
      OP: begin
        if (is_rd && (RD_LAT != 0)) begin
          state_d = RDWAIT;
          wr_d    = 1'b0;
        end else begin
          advance = 1'b1;
          cmp_en  = is_rd;
        end
      end
      RDWAIT: begin
        advance = 1'b1;
        cmp_en  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    mism = cmp_en && (ram_dout != rd_exp(elem_q));
`ifdef BIST_CONT_ON_FAIL_EN
    first = (err_q == '0);
    if (mism && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
`else
    first = 1'b1;
`endif
    if (mism && first) begin
      faddr_d = addr_q;
      felem_d = elem_q;
      fexp_d  = rd_exp(elem_q);
      fact_d  = ram_dout;
    end

    // Next op: second half of the pair, next address, or first address of the next element
    at_end   = (addr_q == (is_down(elem_q) ? '0 : LAST));
    nxt_elem = elem_q;
    nxt_op   = 1'b0;
    nxt_addr = addr_q;
    fin      = 1'b0;
    if ((elem_q != 3'd0) && (elem_q != 3'd5) && !op_q) begin
      nxt_op = 1'b1;
    end else if (!at_end) begin
      nxt_addr = is_down(elem_q) ? addr_q - AW'(1) : addr_q + AW'(1);
    end else if (elem_q == 3'd5) begin
      fin = 1'b1;
    end else begin
      nxt_elem = elem_q + 3'd1;
      nxt_addr = is_down(nxt_elem) ? LAST : '0;
    end

`ifdef BIST_CONT_ON_FAIL_EN
    stop = fin;
`else
    stop = fin || mism;
`endif

    if (advance) begin
      if (stop) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        wr_d    = 1'b0;
        addr_d  = '0;
`ifdef BIST_CONT_ON_FAIL_EN
        pass_d  = (err_d == '0);
`else
        pass_d  = !mism;
`endif
      end else begin
        state_d = OP;
        elem_d  = nxt_elem;
        op_d    = nxt_op;
        addr_d  = nxt_addr;
        wr_d    = (nxt_elem == 3'd0) || nxt_op;
        din_d   = wr_val(nxt_elem);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      elem_q  <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      faddr_q <= '0;
      felem_q <= '0;
      fexp_q  <= '0;
      fact_q  <= '0;
`ifdef BIST_CONT_ON_FAIL_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      faddr_q <= faddr_d;
      felem_q <= felem_d;
      fexp_q  <= fexp_d;
      fact_q  <= fact_d;
`ifdef BIST_CONT_ON_FAIL_EN
      err_q   <= err_d;
`endif
    end
  end

  assign ram_addr  = addr_q;
  assign ram_din   = din_q;
  assign ram_wr    = wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = faddr_q;
  assign fail_elem = felem_q;
  assign fail_exp  = fexp_q;
  assign fail_act  = fact_q;
`ifdef BIST_CONT_ON_FAIL_EN
  assign err_cnt   = err_q;
`endif

endmodule
